// File: rtl/apb_arb_master.sv
// Round-robin APB master for two requesters (IDLE -> SETUP -> ACCESS), every output registered; ack >= 3 cycles after grant.
// Requesters hold valid until acked and wait while a transfer is in flight; `APB_ARB_TIMEOUT_EN adds an ACCESS wait limit.
module apb_arb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          req_ack,
    output logic [DATA_W-1:0]   req_rdata,
    output logic                req_err,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t     state;
    logic       grant;
    logic       last_grant;
    logic       pick;
    logic [1:0] cand;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("apb_arb_master: TIMEOUT must be at least 1");
    end

    // The acked requester only sees its pulse at the next edge, so its valid is stale for one cycle.
    assign cand = req_valid & ~req_ack;

    always_comb begin
        pick = 1'b0;
        case (cand)
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_grant;
            default: pick = 1'b0;
        endcase
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    assign req_err = 1'b0;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state      <= IDLE;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            req_ack    <= 2'b00;
            req_rdata  <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
            req_err    <= 1'b0;
            wait_cnt   <= '0;
`endif
        end else begin
            req_ack <= 2'b00;
`ifdef APB_ARB_TIMEOUT_EN
            req_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|cand) begin
                        grant  <= pick;
                        pwrite <= pick ? req_write[1] : req_write[0];
                        paddr  <= pick ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
                        pwdata <= pick ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
                        psel   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ACCESS: begin
                    if (pready) begin
                        req_ack    <= grant ? 2'b10 : 2'b01;
                        if (!pwrite) begin
                            req_rdata <= prdata;
                        end
                        last_grant <= grant;
                        psel       <= 1'b0;
                        penable    <= 1'b0;
                        state      <= IDLE;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        req_ack    <= grant ? 2'b10 : 2'b01;
                        req_err    <= 1'b1;
                        req_rdata  <= '0;
                        last_grant <= grant;
                        psel       <= 1'b0;
                        penable    <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_arb_master.sv
// Bench for apb_arb_master: directed vector table, corner sequences and a randomized run against a rule-level model.
module tb_apb_arb_master;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          pclk = 1'b0;
    logic          presetn;
    logic [1:0]    req_valid, req_write, req_ack;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [DW-1:0] req_rdata, pwdata, prdata;
    logic          req_err, psel, penable, pwrite, pready;
    logic [AW-1:0] paddr;

    int total = 0;
    int bad   = 0;

    always #5 pclk = ~pclk;

    apb_arb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .req_rdata(req_rdata), .req_err(req_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready)
    );

    typedef struct {
        logic        who;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rd;
        logic [1:0]  exp_ack;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge pclk);
    endtask

    task automatic do_reset();
        presetn   = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        pready    = 1'b0;
        prdata    = '0;
        repeat (3) step();
        presetn = 1'b1;
        step();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int w;
        w = v.who ? 1 : 0;
        req_write[w] = v.wr;
        req_addr[w*AW +: AW]  = v.addr;
        req_wdata[w*DW +: DW] = v.wdata;
        req_valid[w] = 1'b1;
        step();
        chk($sformatf("v%0d setup psel/penable", idx), {psel, penable}, 2'b10);
        chk($sformatf("v%0d setup paddr", idx), paddr, v.addr);
        chk($sformatf("v%0d setup pwrite", idx), pwrite, v.wr);
        chk($sformatf("v%0d setup pwdata", idx), pwdata, v.wdata);
        step();
        for (int k = 0; k <= v.waits; k++) begin
            chk($sformatf("v%0d access%0d psel/penable", idx, k), {psel, penable}, 2'b11);
            chk($sformatf("v%0d access%0d paddr/pwrite", idx, k), {paddr, pwrite}, {v.addr, v.wr});
            chk($sformatf("v%0d access%0d no ack", idx, k), req_ack, 2'b00);
            pready = (k == v.waits);
            prdata = v.rd;
            step();
        end
        chk($sformatf("v%0d ack", idx), req_ack, v.exp_ack);
        chk($sformatf("v%0d rdata", idx), req_rdata, v.exp_rdata);
        chk($sformatf("v%0d err", idx), req_err, 1'b0);
        chk($sformatf("v%0d end psel/penable", idx), {psel, penable}, 2'b00);
        req_valid[w] = 1'b0;
        pready = 1'b0;
        step();
        chk($sformatf("v%0d idle after", idx), {psel, req_ack}, 3'b000);
    endtask

    // Randomized-run model state
    logic [1:0]  pending, prev_valid, prev_ack, cand;
    logic        prev_psel, prev_pen, prev_pready;
    logic [31:0] prev_prdata, m_rdata, l_addr, l_wdata;
    logic        m_last, m_grant, l_write, g;
    logic [31:0] seen_addr;
    int          n, got, ackcnt;

    initial begin
        do_reset();
        chk("reset psel", psel, 1'b0);
        chk("reset penable", penable, 1'b0);
        chk("reset pwrite", pwrite, 1'b0);
        chk("reset paddr", paddr, 32'h0);
        chk("reset pwdata", pwdata, 32'h0);
        chk("reset req_ack", req_ack, 2'b00);
        chk("reset req_rdata", req_rdata, 32'h0);
        chk("reset req_err", req_err, 1'b0);

        vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 0, 32'h1111_1111, 2'b01, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 4, 32'h1234_5678, 2'b10, 32'h1234_5678};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0044, 32'h3C3C_3C3C, 1, 32'hDEAD_BEEF, 2'b01, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_007C, 32'h0BAD_F00D, 2, 32'hFFFF_0000, 2'b10, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 0, 32'h0F0F_0F0F, 2'b01, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 0, 32'h0000_0000, 2'b10, 32'h0000_0000};
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Contention from reset: grants must alternate 0,1,0,1 with a psel=0 cycle between.
        do_reset();
        req_addr  = {32'h0000_0B00, 32'h0000_0A00};
        req_wdata = {32'hBBBB_0000, 32'hAAAA_0000};
        req_write = 2'b11;
        req_valid = 2'b11;
        pready    = 1'b1;
        for (int t = 0; t < 4; t++) begin
            n = 0; got = 0; seen_addr = '0;
            while (got == 0 && n < 10) begin
                step();
                n++;
                if (psel && !penable) seen_addr = paddr;
                if (req_ack != 2'b00) got = 1;
            end
            chk($sformatf("cont%0d ack seen", t), got, 1);
            chk($sformatf("cont%0d ack", t), req_ack, (t % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("cont%0d latency", t), n, 3);
            chk($sformatf("cont%0d psel gap", t), psel, 1'b0);
            chk($sformatf("cont%0d paddr", t), seen_addr, (t % 2 == 0) ? 32'h0000_0A00 : 32'h0000_0B00);
        end
        req_valid = 2'b00;
        pready = 1'b0;
        repeat (2) step();

        // Asynchronous reset in ACCESS discards the transfer; req0 wins afterwards.
        req_addr  = {32'h0000_0BB0, 32'h0000_0AA0};
        req_wdata = {32'h5555_5555, 32'h6666_6666};
        req_write = 2'b00;
        req_valid = 2'b10;
        step();
        step();
        chk("rst precondition penable", {psel, penable}, 2'b11);
        req_valid = 2'b11;
        #2 presetn = 1'b0;
        #1;
        chk("rst async psel/penable", {psel, penable}, 2'b00);
        chk("rst async paddr", paddr, 32'h0);
        chk("rst async pwdata/pwrite", {pwdata, pwrite}, 33'h0);
        chk("rst async ack/err", {req_ack, req_err}, 3'b000);
        chk("rst async rdata", req_rdata, 32'h0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("rst hold%0d", k), {req_ack, psel}, 3'b000);
        end
        presetn = 1'b1;
        step();
        chk("rst restart psel", {psel, penable}, 2'b10);
        chk("rst restart req0 first", paddr, 32'h0000_0AA0);
        step();
        pready = 1'b1;
        prdata = 32'h0000_0055;
        step();
        chk("rst restart ack", req_ack, 2'b01);
        chk("rst restart rdata", req_rdata, 32'h0000_0055);
        req_valid = 2'b00;
        pready = 1'b0;
        repeat (2) step();

        // Stuck slave.
        req_write = 2'b00;
        req_valid = 2'b01;
        step();
        step();
`ifdef APB_ARB_TIMEOUT_EN
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("to wait%0d", k), {req_ack, psel}, 3'b001);
            step();
        end
        chk("to ack", req_ack, 2'b01);
        chk("to err", req_err, 1'b1);
        chk("to rdata", req_rdata, 32'h0);
        chk("to psel dropped", {psel, penable}, 2'b00);
`else
        ackcnt = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (req_ack != 2'b00) ackcnt++;
        end
        chk("stuck still psel/penable", {psel, penable}, 2'b11);
        chk("stuck no ack", ackcnt, 0);
        pready = 1'b1;
        step();
        chk("stuck release ack", {req_ack, req_err}, 3'b010);
`endif
        req_valid = 2'b00;
        pready = 1'b0;
        repeat (2) step();

        // Randomized run against a rule-level model.
        do_reset();
        pending = '0; prev_valid = '0; prev_ack = '0;
        prev_psel = 1'b0; prev_pen = 1'b0; prev_pready = 1'b0; prev_prdata = '0;
        m_rdata = '0; m_last = 1'b1; m_grant = 1'b0;
        l_addr = '0; l_wdata = '0; l_write = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            cand = prev_valid & ~prev_ack;
            if (!prev_psel) begin
                if (cand != 2'b00) begin
                    g = (cand == 2'b11) ? ~m_last : cand[1];
                    m_grant = g;
                    l_addr  = req_addr[(g ? 1 : 0)*AW +: AW];
                    l_wdata = req_wdata[(g ? 1 : 0)*DW +: DW];
                    l_write = req_write[g ? 1 : 0];
                    chk("rnd grant setup", {psel, penable, req_ack}, 4'b1000);
                    chk("rnd grant fields", {paddr, pwdata, pwrite}, {l_addr, l_wdata, l_write});
                end else begin
                    chk("rnd idle", {psel, req_ack}, 3'b000);
                end
            end else if (!prev_pen) begin
                chk("rnd access entry", {psel, penable, req_ack}, 4'b1100);
                chk("rnd stable", {paddr, pwdata, pwrite}, {l_addr, l_wdata, l_write});
            end else if (prev_pready) begin
                chk("rnd done", {psel, penable, req_err}, 3'b000);
                chk("rnd ack", req_ack, m_grant ? 2'b10 : 2'b01);
                if (!l_write) m_rdata = prev_prdata;
                chk("rnd rdata", req_rdata, m_rdata);
                m_last = m_grant;
            end else begin
                chk("rnd wait", {psel, penable, req_ack}, 4'b1100);
                chk("rnd wait stable", {paddr, pwdata, pwrite}, {l_addr, l_wdata, l_write});
            end
            prev_psel = psel;
            prev_pen  = penable;
            prev_ack  = req_ack;
            for (int i = 0; i < 2; i++) begin
                if (req_ack[i]) begin
                    pending[i]   = 1'b0;
                    req_valid[i] = 1'b0;
                end else if (!pending[i] && cyc < 1800 && $urandom_range(0, 2) == 0) begin
                    pending[i]   = 1'b1;
                    req_valid[i] = 1'b1;
                    req_write[i] = 1'($urandom_range(0, 1));
                    req_addr[i*AW +: AW]  = $urandom;
                    req_wdata[i*DW +: DW] = $urandom;
                end else if (pending[i] && req_valid[i] && psel && m_grant == i[0]
                             && $urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            pready = (cyc < 1800) ? 1'($urandom_range(0, 1)) : 1'b1;
            prdata = $urandom;
            prev_valid  = req_valid;
            prev_pready = pready;
            prev_prdata = prdata;
            step();
        end
        chk("rnd all drained", pending, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, the APB and requester address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, the APB and requester data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, the ACCESS-phase wait limit in cycles, used only under APB_ARB_TIMEOUT_EN.
REQ-004 The block SHALL have port pclk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port presetn, input, 1, the reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port req_valid, input, 2, request per requester i, held high until req_ack[i].
REQ-007 The block SHALL have port req_write, input, 2, 1 = write and 0 = read, per requester.
REQ-008 The block SHALL have port req_addr, input, 2*ADDR_W, with requester i at bits [i*ADDR_W +: ADDR_W].
REQ-009 The block SHALL have port req_wdata, input, 2*DATA_W, with requester i at bits [i*DATA_W +: DATA_W].
REQ-010 The block SHALL have port req_ack, output, 2, a one-cycle completion pulse to the granted requester.
REQ-011 The block SHALL have port req_rdata, output, DATA_W, read data, valid in the req_ack cycle.
REQ-012 The block SHALL have port req_err, output, 1, a timeout flag, valid in the req_ack cycle.
REQ-013 The block SHALL have ports psel, penable and pwrite, each output, 1, the APB control outputs.
REQ-014 The block SHALL have ports paddr (ADDR_W) and pwdata (DATA_W), outputs, the APB address and write data.
REQ-015 The block SHALL have ports prdata (input, DATA_W) and pready (input, 1), the APB slave response.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP and ACCESS, and all outputs SHALL be registered.
REQ-017 In IDLE with any req_valid set, the block SHALL grant one requester, latch its write/addr/wdata, and enter SETUP, driving psel=1 and penable=0 on the next cycle.
REQ-018 Arbitration SHALL be round-robin: with both requests valid, grant the requester not equal to last_grant; with one valid, grant that one.
REQ-019 SETUP SHALL move unconditionally to ACCESS after one cycle, driving penable=1 while psel stays 1.
REQ-020 paddr, pwdata and pwrite SHALL stay stable from SETUP until the transfer ends.
REQ-021 In ACCESS, the block SHALL hold all APB outputs until pready=1 is sampled.
REQ-022 When pready=1 is sampled, the block SHALL pulse req_ack[g] for one cycle, drive req_rdata=prdata for reads (else hold the previous value), drive req_err=0, set last_grant=g, clear psel and penable, and return to IDLE.
REQ-023 Minimum latency from req_valid sampled in IDLE to req_ack SHALL be 3 cycles, with at least one idle cycle (psel=0) between transfers.
REQ-024 Dropping req_valid after a grant SHALL NOT abort the transfer; the ack is still issued.
REQ-025 A new request arriving during SETUP or ACCESS SHALL wait for IDLE, and req_ack SHALL never be high for both bits at once.

Reset
REQ-026 While presetn=0, the block SHALL immediately force state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, req_ack=0, req_rdata=0, req_err=0 and last_grant=1, so that requester 0 wins first.
REQ-027 Reset asserted mid-transfer SHALL discard the transfer with no ack, and operation SHALL restart from IDLE on the first edge after release.

Configuration
REQ-028 With APB_ARB_TIMEOUT_EN defined, a counter SHALL clear on ACCESS entry and count cycles in ACCESS with pready=0.
REQ-029 With APB_ARB_TIMEOUT_EN defined, on reaching TIMEOUT the block SHALL end the transfer: clear psel and penable, pulse req_ack[g] with req_err=1 and req_rdata=0, update last_grant, and return to IDLE.
REQ-030 With APB_ARB_TIMEOUT_EN undefined, ACCESS SHALL wait indefinitely, req_err SHALL be constant 0, and no counter SHALL be built.

Verification
REQ-031 Single write: req0 write addr 0x10 data 0xA5A5A5A5, pready=1 -> psel at +1, penable at +2, req_ack=2'b01 at +3, APB pins match.
REQ-032 Read with wait states: req1 read addr 0x20, pready held 0 for 4 ACCESS cycles, then 1 with prdata 0x12345678 -> req_ack=2'b10 with req_rdata 0x12345678, APB outputs stable throughout.
REQ-033 Contention: both requesters valid continuously from reset -> grants alternate 0,1,0,1 across four transfers, with one psel=0 cycle between each.
REQ-034 Reset mid-ACCESS: presetn low while penable=1 -> all outputs 0 without waiting for a clock edge, no ack; after release, the pending req0 is granted first.
REQ-035 Timeout: with APB_ARB_TIMEOUT_EN defined, TIMEOUT=16 and pready stuck 0 -> req_ack pulse with req_err=1 at 16 ACCESS cycles and psel dropped; with the macro undefined, psel is still high after 100 cycles.
